// File: rtl/wb_lock_release.sv
// Writeback-side release queue: records the locks taken at issue and replays them
// as registered put_* pulses, oldest first, as instructions complete writeback.
module wb_lock_release #(
    parameter int L2_DEPTH = 2,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic                issue_gpr_a,
    input  logic [4:0]          issue_gpr_a_name,
    input  logic                issue_gpr_b,
    input  logic [4:0]          issue_gpr_b_name,
    input  logic                issue_xercr,
    input  logic                issue_spr,
    input  logic [5:0]          issue_spr_name,
    input  logic                issue_sspr,
    input  logic [5:0]          issue_sspr_name,
    input  logic                issue_spr_generic,
    input  logic                wb_valid,
    input  logic                flush,
    output logic                full,
    output logic                empty,
    output logic [L2_DEPTH:0]   count,
    output logic                put_gpr_a,
    output logic [4:0]          put_gpr_a_name,
    output logic                put_gpr_b,
    output logic [4:0]          put_gpr_b_name,
    output logic                put_xercr,
    output logic                put_spr,
    output logic [5:0]          put_spr_name,
    output logic                put_sspr,
    output logic [5:0]          put_sspr_name,
    output logic                put_spr_generic,
    output logic                reset_scoreboard,
    output logic                err_overflow,
    output logic                err_underflow
);

    typedef struct packed {
        logic       gpr_a;
        logic [4:0] gpr_a_name;
        logic       gpr_b;
        logic [4:0] gpr_b_name;
        logic       xercr;
        logic       spr;
        logic [5:0] spr_name;
        logic       sspr;
        logic [5:0] sspr_name;
        logic       spr_generic;
    } rec_t;

    rec_t                mem_q [DEPTH];
    logic [L2_DEPTH-1:0] head_q, head_d;
    logic [L2_DEPTH-1:0] tail_q, tail_d;
    logic [L2_DEPTH:0]   count_q, count_d;
    rec_t                put_q, put_d;
    logic                rsb_q, rsb_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    rec_t issue_rec;
    rec_t head_rec;
    logic push_ok;
    logic pop_ok;

    assign issue_rec = '{gpr_a: issue_gpr_a, gpr_a_name: issue_gpr_a_name,
                         gpr_b: issue_gpr_b, gpr_b_name: issue_gpr_b_name,
                         xercr: issue_xercr,
                         spr: issue_spr, spr_name: issue_spr_name,
                         sspr: issue_sspr, sspr_name: issue_sspr_name,
                         spr_generic: issue_spr_generic};

    assign full     = (count_q == (L2_DEPTH+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign head_rec = mem_q[head_q];

    // A pop in the same cycle frees a slot, so a push while full is still accepted.
    assign pop_ok  = wb_valid && !empty && !flush;
    assign push_ok = issue_valid && !flush && (!full || pop_ok);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) tail_d = tail_q + L2_DEPTH'(1);
            if (pop_ok)  head_d = head_q + L2_DEPTH'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (L2_DEPTH+1)'(1);
                2'b01:   count_d = count_q - (L2_DEPTH+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        put_d = '0;
        if (pop_ok) begin
            put_d.gpr_a       = head_rec.gpr_a;
            put_d.gpr_a_name  = head_rec.gpr_a ? head_rec.gpr_a_name : '0;
            put_d.gpr_b       = head_rec.gpr_b;
            put_d.gpr_b_name  = head_rec.gpr_b ? head_rec.gpr_b_name : '0;
            put_d.xercr       = head_rec.xercr;
            put_d.spr         = head_rec.spr;
            put_d.spr_name    = head_rec.spr ? head_rec.spr_name : '0;
            put_d.sspr        = head_rec.sspr;
            put_d.sspr_name   = head_rec.sspr ? head_rec.sspr_name : '0;
            put_d.spr_generic = head_rec.spr_generic;
        end
        rsb_d = flush;
        ovf_d = ovf_q | (issue_valid && !flush && full && !pop_ok);
        unf_d = unf_q | (wb_valid && !flush && empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            put_q   <= '0;
            rsb_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            put_q   <= put_d;
            rsb_q   <= rsb_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[tail_q] <= issue_rec;
    end

    assign count            = count_q;
    assign put_gpr_a        = put_q.gpr_a;
    assign put_gpr_a_name   = put_q.gpr_a_name;
    assign put_gpr_b        = put_q.gpr_b;
    assign put_gpr_b_name   = put_q.gpr_b_name;
    assign put_xercr        = put_q.xercr;
    assign put_spr          = put_q.spr;
    assign put_spr_name     = put_q.spr_name;
    assign put_sspr         = put_q.sspr;
    assign put_sspr_name    = put_q.sspr_name;
    assign put_spr_generic  = put_q.spr_generic;
    assign reset_scoreboard = rsb_q;
    assign err_overflow     = ovf_q;
    assign err_underflow    = unf_q;

`ifdef SIM
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (issue_valid && !flush && full && !pop_ok)
                $fatal(1, "wb_lock_release: push dropped, queue full");
            if (wb_valid && !flush && empty)
                $fatal(1, "wb_lock_release: writeback with empty queue");
            if (issue_valid && issue_gpr_a && issue_gpr_b && issue_gpr_a_name == issue_gpr_b_name)
                $fatal(1, "wb_lock_release: duplicate GPR lock in one record");
        end
    end
`endif

endmodule

// File: tb/tb_wb_lock_release.sv
// Scoreboarded bench for wb_lock_release: a reference FIFO predicts each cycle's puts.
module tb_wb_lock_release;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic       issue_gpr_a;
    logic [4:0] issue_gpr_a_name;
    logic       issue_gpr_b;
    logic [4:0] issue_gpr_b_name;
    logic       issue_xercr;
    logic       issue_spr;
    logic [5:0] issue_spr_name;
    logic       issue_sspr;
    logic [5:0] issue_sspr_name;
    logic       issue_spr_generic;
    logic       wb_valid;
    logic       flush;
    logic       full, empty;
    logic [2:0] count;
    logic       put_gpr_a, put_gpr_b, put_xercr, put_spr, put_sspr, put_spr_generic;
    logic [4:0] put_gpr_a_name, put_gpr_b_name;
    logic [5:0] put_spr_name, put_sspr_name;
    logic       reset_scoreboard, err_overflow, err_underflow;

    always #5 clk = ~clk;

    wb_lock_release #(.L2_DEPTH(2), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid),
        .issue_gpr_a(issue_gpr_a), .issue_gpr_a_name(issue_gpr_a_name),
        .issue_gpr_b(issue_gpr_b), .issue_gpr_b_name(issue_gpr_b_name),
        .issue_xercr(issue_xercr),
        .issue_spr(issue_spr), .issue_spr_name(issue_spr_name),
        .issue_sspr(issue_sspr), .issue_sspr_name(issue_sspr_name),
        .issue_spr_generic(issue_spr_generic),
        .wb_valid(wb_valid), .flush(flush),
        .full(full), .empty(empty), .count(count),
        .put_gpr_a(put_gpr_a), .put_gpr_a_name(put_gpr_a_name),
        .put_gpr_b(put_gpr_b), .put_gpr_b_name(put_gpr_b_name),
        .put_xercr(put_xercr),
        .put_spr(put_spr), .put_spr_name(put_spr_name),
        .put_sspr(put_sspr), .put_sspr_name(put_sspr_name),
        .put_spr_generic(put_spr_generic),
        .reset_scoreboard(reset_scoreboard),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    typedef struct packed {
        logic       gpr_a;
        logic [4:0] gpr_a_name;
        logic       gpr_b;
        logic [4:0] gpr_b_name;
        logic       xercr;
        logic       spr;
        logic [5:0] spr_name;
        logic       sspr;
        logic [5:0] sspr_name;
        logic       spr_generic;
    } rec_t;

    typedef struct packed {
        rec_t r;
        logic rsb;
    } exp_t;

    rec_t mfifo[$];
    exp_t exp_q[$];
    logic m_ov, m_un;
    int   total = 0;
    int   bad   = 0;

    function automatic rec_t mask(input rec_t r);
        rec_t m = r;
        if (!r.gpr_a) m.gpr_a_name = '0;
        if (!r.gpr_b) m.gpr_b_name = '0;
        if (!r.spr)   m.spr_name   = '0;
        if (!r.sspr)  m.sspr_name  = '0;
        return m;
    endfunction

    function automatic rec_t gpr(input int n);
        rec_t r = '0;
        r.gpr_a      = 1'b1;
        r.gpr_a_name = 5'(n);
        return r;
    endfunction

    function automatic exp_t dut_out();
        exp_t o;
        o.r = '{gpr_a: put_gpr_a, gpr_a_name: put_gpr_a_name,
                gpr_b: put_gpr_b, gpr_b_name: put_gpr_b_name,
                xercr: put_xercr, spr: put_spr, spr_name: put_spr_name,
                sspr: put_sspr, sspr_name: put_sspr_name,
                spr_generic: put_spr_generic};
        o.rsb = reset_scoreboard;
        return o;
    endfunction

    task automatic drive_rec(input rec_t r);
        issue_gpr_a       = r.gpr_a;
        issue_gpr_a_name  = r.gpr_a_name;
        issue_gpr_b       = r.gpr_b;
        issue_gpr_b_name  = r.gpr_b_name;
        issue_xercr       = r.xercr;
        issue_spr         = r.spr;
        issue_spr_name    = r.spr_name;
        issue_sspr        = r.sspr;
        issue_sspr_name   = r.sspr_name;
        issue_spr_generic = r.spr_generic;
    endtask

    // One clock of stimulus; the reference queue predicts the put for the next cycle.
    task automatic cycle(input logic iv, input rec_t r, input logic wv, input logic fl);
        exp_t e;
        int   n;
        logic pop_ok, push_ok;
        issue_valid = iv;
        drive_rec(r);
        wb_valid = wv;
        flush    = fl;
        n        = mfifo.size();
        pop_ok   = wv && !fl && n > 0;
        push_ok  = iv && !fl && (n < 4 || pop_ok);
        e        = '0;
        e.rsb    = fl;
        if (pop_ok) e.r = mask(mfifo[0]);
        if (!fl) begin
            if (iv && n == 4 && !pop_ok) m_ov = 1'b1;
            if (wv && n == 0) m_un = 1'b1;
        end
        if (fl) mfifo.delete();
        else begin
            if (pop_ok)  void'(mfifo.pop_front());
            if (push_ok) mfifo.push_back(r);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
        flush       = 1'b0;
        drive_rec('0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mfifo.delete();
        exp_q.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
    endtask

    task automatic test_reset();
        exp_t got;
        reset = 1'b1;
        issue_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
        drive_rec('0);
        repeat (2) @(posedge clk);
        do_reset();
        got = dut_out();
        total++;
        if (got !== '0) begin bad++; $display("FAIL reset_puts got=%h exp=0", got); end
        total++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0)
            begin bad++; $display("FAIL reset_state count=%0d empty=%b full=%b exp 0/1/0", count, empty, full); end
        total++;
        if (err_overflow !== 1'b0 || err_underflow !== 1'b0)
            begin bad++; $display("FAIL reset_err ov=%b un=%b exp 0/0", err_overflow, err_underflow); end
    endtask

    task automatic test_single();
        exp_t got, e;
        rec_t r = gpr(3);
        r.xercr = 1'b1;
        cycle(1'b1, r, 1'b0, 1'b0);
        total++;
        if (count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        total++;
        if (put_gpr_a !== 1'b1 || put_gpr_a_name !== 5'd3 || put_xercr !== 1'b1)
            begin bad++; $display("FAIL single_put a=%b name=%0d xercr=%b exp 1/3/1", put_gpr_a, put_gpr_a_name, put_xercr); end
        total++;
        if (count !== 3'd0 || empty !== 1'b1) begin bad++; $display("FAIL single_empty count=%0d empty=%b", count, empty); end
        cycle(1'b0, '0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            got = dut_out();
            e = exp_q.pop_front();
            // Only the last queued prediction matches the current outputs.
            if (exp_q.size() == 0) begin
                total++;
                if (got !== e) begin bad++; $display("FAIL single_pulse got=%h exp=%h", got, e); end
            end
        end
    endtask

    task automatic test_fill_drain();
        exp_t got, e;
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, gpr(i), 1'b0, 1'b0);
            void'(exp_q.pop_front());
        end
        total++;
        if (full !== 1'b1 || count !== 3'd4) begin bad++; $display("FAIL fill_full full=%b count=%0d exp 1/4", full, count); end
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            got = dut_out();
            e = exp_q.pop_front();
            total++;
            if (got !== e || put_gpr_a_name !== 5'(i))
                begin bad++; $display("FAIL drain_order got=%h exp=%h name=%0d want=%0d", got, e, put_gpr_a_name, i); end
        end
    endtask

    task automatic test_full_pushpop();
        exp_t got, e;
        int   want [4] = '{6, 7, 8, 9};
        for (int i = 5; i <= 8; i++) begin
            cycle(1'b1, gpr(i), 1'b0, 1'b0);
            void'(exp_q.pop_front());
        end
        cycle(1'b1, gpr(9), 1'b1, 1'b0);
        got = dut_out();
        e = exp_q.pop_front();
        total++;
        if (got !== e || put_gpr_a_name !== 5'd5 || count !== 3'd4)
            begin bad++; $display("FAIL full_pushpop got=%h exp=%h count=%0d", got, e, count); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            got = dut_out();
            e = exp_q.pop_front();
            total++;
            if (got !== e || put_gpr_a_name !== 5'(want[i]))
                begin bad++; $display("FAIL wrap_order got=%h exp=%h name=%0d want=%0d", got, e, put_gpr_a_name, want[i]); end
        end
    endtask

    task automatic test_errors();
        exp_t got, e;
        for (int i = 10; i <= 13; i++) begin
            cycle(1'b1, gpr(i), 1'b0, 1'b0);
            void'(exp_q.pop_front());
        end
        cycle(1'b1, gpr(20), 1'b0, 1'b0);
        void'(exp_q.pop_front());
        total++;
        if (err_overflow !== m_ov || err_overflow !== 1'b1 || count !== 3'd4)
            begin bad++; $display("FAIL overflow ov=%b count=%0d exp 1/4", err_overflow, count); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            got = dut_out();
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin bad++; $display("FAIL ovf_drain got=%h exp=%h", got, e); end
        end
        total++;
        if (err_underflow !== 1'b0) begin bad++; $display("FAIL underflow_early un=%b exp=0", err_underflow); end
        cycle(1'b0, '0, 1'b1, 1'b0);
        got = dut_out();
        e = exp_q.pop_front();
        total++;
        if (got !== e || err_underflow !== m_un || err_underflow !== 1'b1)
            begin bad++; $display("FAIL underflow got=%h exp=%h un=%b", got, e, err_underflow); end
        cycle(1'b1, gpr(21), 1'b1, 1'b0);
        got = dut_out();
        e = exp_q.pop_front();
        total++;
        if (got !== e || count !== 3'd1) begin bad++; $display("FAIL empty_pushpop got=%h exp=%h count=%0d", got, e, count); end
        cycle(1'b0, '0, 1'b1, 1'b0);
        got = dut_out();
        e = exp_q.pop_front();
        total++;
        if (got !== e || put_gpr_a_name !== 5'd21) begin bad++; $display("FAIL empty_pushpop_pop got=%h exp=%h", got, e); end
    endtask

    task automatic test_flush();
        exp_t got, e;
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b1, gpr(i + 13), 1'b0, 1'b0);
            void'(exp_q.pop_front());
        end
        cycle(1'b1, gpr(30), 1'b1, 1'b1);
        got = dut_out();
        e = exp_q.pop_front();
        total++;
        if (got !== e || reset_scoreboard !== 1'b1 || put_gpr_a !== 1'b0 || count !== 3'd0)
            begin bad++; $display("FAIL flush got=%h exp=%h count=%0d", got, e, count); end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b0);
            got = dut_out();
            e = exp_q.pop_front();
            total++;
            if (got !== e || count !== 3'(mfifo.size()))
                begin bad++; $display("FAIL post_flush got=%h exp=%h count=%0d", got, e, count); end
        end
    endtask

    task automatic test_spr_reset();
        exp_t got, e;
        rec_t r = '0;
        r.spr = 1'b1; r.spr_name = 6'd5;
        r.sspr = 1'b1; r.sspr_name = 6'd2;
        r.spr_generic = 1'b1;
        r.gpr_b_name = 5'd7;
        cycle(1'b1, r, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        cycle(1'b0, '0, 1'b1, 1'b0);
        got = dut_out();
        e = exp_q.pop_front();
        total++;
        if (got !== e || put_spr_name !== 6'd5 || put_sspr_name !== 6'd2 || put_spr_generic !== 1'b1 || put_gpr_b_name !== 5'd0)
            begin bad++; $display("FAIL spr_put got=%h exp=%h", got, e); end
        cycle(1'b1, gpr(1), 1'b0, 1'b0);
        void'(exp_q.pop_front());
        cycle(1'b1, gpr(2), 1'b1, 1'b0);
        void'(exp_q.pop_front());
        issue_valid = 1'b1;
        drive_rec(gpr(3));
        wb_valid = 1'b1;
        do_reset();
        issue_valid = 1'b0;
        wb_valid = 1'b0;
        drive_rec('0);
        got = dut_out();
        total++;
        if (got !== '0 || count !== 3'd0 || empty !== 1'b1)
            begin bad++; $display("FAIL mid_reset got=%h count=%0d exp 0/0", got, count); end
        total++;
        if (err_overflow !== 1'b0 || err_underflow !== 1'b0)
            begin bad++; $display("FAIL mid_reset_err ov=%b un=%b exp 0/0", err_overflow, err_underflow); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_full_pushpop();
        test_errors();
        test_flush();
        test_spr_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_lock_release.md
Name: wb_lock_release

Overview:
- Writeback-side counterpart of the decode register scoreboard.
- At issue, decode pushes a record of the resources the instruction locked (its get_* set).
- At writeback, this block pops records in program order and produces the matching put_* release pulses back to the scoreboard.
- On pipeline flush it discards all outstanding records and requests a scoreboard reset.

Parameters:
- L2_DEPTH, 2: log2 of queue depth.
- DEPTH, 4: number of outstanding issued-instruction records (must equal 2**L2_DEPTH).

Ports:
- clk  input  1  clock
- reset  input  1  reset; synchronous, active-high
- issue_valid  input  1  push one record this cycle
- issue_gpr_a  input  1  record locks GPR (port a)
- issue_gpr_a_name  input  5  GPR name, port a
- issue_gpr_b  input  1  record locks GPR (port b)
- issue_gpr_b_name  input  5  GPR name, port b
- issue_xercr  input  1  record locks XER/CR
- issue_spr  input  1  record locks SPR
- issue_spr_name  input  6  SPR name
- issue_sspr  input  1  record locks special SPR
- issue_sspr_name  input  6  special SPR name
- issue_spr_generic  input  1  record holds generic SPR lock
- wb_valid  input  1  oldest outstanding instruction completes writeback this cycle
- flush  input  1  annul all outstanding instructions
- full  output  1  no free entry; decode must not issue
- empty  output  1  no outstanding records
- count  output  L2_DEPTH+1  occupancy, 0..DEPTH
- put_gpr_a, put_gpr_a_name  output  1, 5  GPR release, port a
- put_gpr_b, put_gpr_b_name  output  1, 5  GPR release, port b
- put_xercr  output  1  XER/CR release
- put_spr, put_spr_name  output  1, 6  SPR release
- put_sspr, put_sspr_name  output  1, 6  special SPR release
- put_spr_generic  output  1  generic SPR release
- reset_scoreboard  output  1  one-cycle scoreboard clear request
- err_overflow  output  1  sticky: push dropped because queue was full
- err_underflow  output  1  sticky: wb_valid received while queue was empty

Behaviour:
- Storage: circular buffer of DEPTH records; head and tail pointers are L2_DEPTH bits wide and wrap modulo DEPTH; count tracks occupancy.
- full = (count == DEPTH); empty = (count == 0). Both are combinational from count.
- Push: when issue_valid is high and the queue is not full, write the record at tail; tail+1; count+1.
- Pop: when wb_valid is high and the queue is not empty, read the record at head; head+1; count-1.
- Put outputs are registered. A pop in cycle N drives every put_* enable from the popped record's flags during cycle N+1, for exactly one cycle. Name outputs carry the recorded names.
- A name output is don't-care when its enable is 0; the implementation drives it to 0.
- With no pop, all put_* enables are 0 in the next cycle.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full, this is still legal and the push is accepted, because the pop frees a slot.
  - When empty, the pop is an underflow and the push is accepted: count becomes 1, and no put is generated.
- Push while full without pop: record dropped, state unchanged, err_overflow set.
- Pop while empty: no put generated, err_underflow set.
- A record with no flags set still occupies an entry; popping it produces all-zero puts.
- Flush has priority over push and pop in the same cycle:
  - head, tail and count go to 0.
  - The next cycle has all put_* = 0 and reset_scoreboard = 1 for one cycle.
  - Puts already registered from a pop in the previous cycle still appear during the flush cycle. The scoreboard resolves this because reset_scoreboard overrides later.
- reset:
  - Pointers and count go to 0.
  - All put_* enables, all names, reset_scoreboard, err_overflow and err_underflow go to 0.
  - Storage contents are don't-care.
  - reset mid-operation discards all records and does not assert reset_scoreboard (the scoreboard has its own reset).
- err_* flags clear only on reset.
- SIM builds: $fatal on overflow, on underflow, and on a push with issue_gpr_a && issue_gpr_b && equal names.

Test Plan:
- Push {gpr_a=1, r3; xercr=1} then wb_valid 3 cycles later -> cycle after pop: put_gpr_a=1, name=3, put_xercr=1 for one cycle; count 1->0; empty=1.
- Push 4 records with gpr_a names 1, 2, 3, 4 -> full=1, count=4. Then pop 4 times consecutively -> puts for names 1, 2, 3, 4 in order on consecutive cycles.
- Fill to full, then push and pop in the same cycle (new name 9) -> count stays 4; the put carries the old head name. Subsequent pops return the remaining records, then 9, confirming pointer wrap-around.
- Push while full without pop -> err_overflow=1, count=4. Pop on empty after draining -> err_underflow=1, no put.
- With 3 records queued, assert flush together with issue_valid and wb_valid -> count=0; next cycle reset_scoreboard=1 with all put_* enables 0; no further puts until new pushes.
- Push {spr=1, name 5; sspr=1, name 2; spr_generic=1} and pop -> put_spr=1 name 5, put_sspr=1 name 2, put_spr_generic=1. Then assert reset mid-queue -> count=0 and outputs 0 next cycle.
